// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs (ALU/MUL/LSU) feeding one round-robin CDB broadcast per cycle.
// Optional feature macro CDB_BYPASS_EN: an empty FU's incoming result may win arbitration directly.

module cdb_arbiter #(
  parameter int BUF_DEPTH = 2,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32,
  parameter int ROB_W     = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [TAG_W-1:0]  alu_tag_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic [ROB_W-1:0]  alu_rob_idx_i,
  input  logic              mul_valid_i,
  output logic              mul_ready_o,
  input  logic [TAG_W-1:0]  mul_tag_i,
  input  logic [DATA_W-1:0] mul_data_i,
  input  logic [ROB_W-1:0]  mul_rob_idx_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [TAG_W-1:0]  lsu_tag_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  input  logic [ROB_W-1:0]  lsu_rob_idx_i,
  output logic              cdb_en_o,
  output logic [TAG_W-1:0]  cdb_tag_o,
  output logic [DATA_W-1:0] cdb_data_o,
  output logic [ROB_W-1:0]  cdb_rob_idx_o
);

  localparam int NFU   = 3;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2
  } fu_e;

  logic              w_in_valid [NFU];
  logic [TAG_W-1:0]  w_in_tag   [NFU];
  logic [DATA_W-1:0] w_in_data  [NFU];
  logic [ROB_W-1:0]  w_in_rob   [NFU];

  logic [TAG_W-1:0]  r_tag_mem  [NFU][BUF_DEPTH];
  logic [DATA_W-1:0] r_data_mem [NFU][BUF_DEPTH];
  logic [ROB_W-1:0]  r_rob_mem  [NFU][BUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr   [NFU];
  logic [PTR_W-1:0]  r_rd_ptr   [NFU];
  logic [CNT_W-1:0]  r_count    [NFU];
  fu_e               r_rr_ptr;

  logic              r_cdb_en;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic [ROB_W-1:0]  r_cdb_rob;

  logic              w_ready    [NFU];
  logic              w_nonempty [NFU];
  logic              w_accept   [NFU];
  logic              w_cand     [NFU];
  logic              w_push     [NFU];
  logic              w_pop      [NFU];

  logic              w_grant_valid;
  logic [1:0]        w_grant_idx;
  logic              w_grant_bypass;
  logic [TAG_W-1:0]  w_win_tag;
  logic [DATA_W-1:0] w_win_data;
  logic [ROB_W-1:0]  w_win_rob;

  function automatic logic [1:0] rr_index(input fu_e base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NFU) s = s - NFU;
    return s[1:0];
  endfunction

  always_comb begin
    w_in_valid[0] = alu_valid_i;
    w_in_tag[0]   = alu_tag_i;
    w_in_data[0]  = alu_data_i;
    w_in_rob[0]   = alu_rob_idx_i;
    w_in_valid[1] = mul_valid_i;
    w_in_tag[1]   = mul_tag_i;
    w_in_data[1]  = mul_data_i;
    w_in_rob[1]   = mul_rob_idx_i;
    w_in_valid[2] = lsu_valid_i;
    w_in_tag[2]   = lsu_tag_i;
    w_in_data[2]  = lsu_data_i;
    w_in_rob[2]   = lsu_rob_idx_i;
  end

  // Tag 0 is the hardwired-zero register: accepted at the handshake but never stored.
  always_comb begin
    for (int f = 0; f < NFU; f++) begin
      w_ready[f]    = (r_count[f] < CNT_W'(BUF_DEPTH));
      w_nonempty[f] = (r_count[f] != '0);
      w_accept[f]   = w_in_valid[f] & w_ready[f] & (w_in_tag[f] != '0) & ~flush_i & ~reset_i;
`ifdef CDB_BYPASS_EN
      w_cand[f]     = (w_nonempty[f] | w_accept[f]) & ~flush_i & ~reset_i;
`else
      w_cand[f]     = w_nonempty[f] & ~flush_i & ~reset_i;
`endif
    end
  end

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = 2'd0;
    for (int k = 0; k < NFU; k++) begin
      if (!w_grant_valid && w_cand[rr_index(r_rr_ptr, k)]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = rr_index(r_rr_ptr, k);
      end
    end
`ifdef CDB_BYPASS_EN
    w_grant_bypass = w_grant_valid & ~w_nonempty[w_grant_idx];
`else
    w_grant_bypass = 1'b0;
`endif
  end

  always_comb begin
    w_win_tag  = r_tag_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
    w_win_data = r_data_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
    w_win_rob  = r_rob_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
    if (w_grant_bypass) begin
      w_win_tag  = w_in_tag[w_grant_idx];
      w_win_data = w_in_data[w_grant_idx];
      w_win_rob  = w_in_rob[w_grant_idx];
    end
  end

  // A bypassed winner leaves its FIFO untouched: neither pushed nor popped.
  always_comb begin
    for (int f = 0; f < NFU; f++) begin
      w_pop[f]  = w_grant_valid & ~w_grant_bypass & (w_grant_idx == 2'(f));
      w_push[f] = w_accept[f] & ~(w_grant_bypass & (w_grant_idx == 2'(f)));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int f = 0; f < NFU; f++) begin
      if (w_push[f]) begin
        r_tag_mem[f][r_wr_ptr[f]]  <= w_in_tag[f];
        r_data_mem[f][r_wr_ptr[f]] <= w_in_data[f];
        r_rob_mem[f][r_wr_ptr[f]]  <= w_in_rob[f];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int f = 0; f < NFU; f++) begin
      if (reset_i || flush_i) begin
        r_wr_ptr[f] <= '0;
        r_rd_ptr[f] <= '0;
        r_count[f]  <= '0;
      end else begin
        if (w_push[f]) r_wr_ptr[f] <= r_wr_ptr[f] + PTR_W'(1);
        if (w_pop[f])  r_rd_ptr[f] <= r_rd_ptr[f] + PTR_W'(1);
        case ({w_push[f], w_pop[f]})
          2'b10:   r_count[f] <= r_count[f] + CNT_W'(1);
          2'b01:   r_count[f] <= r_count[f] - CNT_W'(1);
          default: r_count[f] <= r_count[f];
        endcase
      end
    end
  end

  // Flush suppresses every candidate, so the pointer naturally holds through it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rr_ptr   <= FU_ALU;
      r_cdb_en   <= 1'b0;
      r_cdb_tag  <= '0;
      r_cdb_data <= '0;
      r_cdb_rob  <= '0;
    end else if (w_grant_valid) begin
      r_rr_ptr   <= (w_grant_idx == 2'd2) ? FU_ALU : fu_e'(w_grant_idx + 2'd1);
      r_cdb_en   <= 1'b1;
      r_cdb_tag  <= w_win_tag;
      r_cdb_data <= w_win_data;
      r_cdb_rob  <= w_win_rob;
    end else begin
      r_cdb_en   <= 1'b0;
      r_cdb_tag  <= '0;
      r_cdb_data <= '0;
      r_cdb_rob  <= '0;
    end
  end

  assign alu_ready_o   = w_ready[0];
  assign mul_ready_o   = w_ready[1];
  assign lsu_ready_o   = w_ready[2];
  assign cdb_en_o      = r_cdb_en;
  assign cdb_tag_o     = r_cdb_tag;
  assign cdb_data_o    = r_cdb_data;
  assign cdb_rob_idx_o = r_cdb_rob;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a random run checked against a queue-based model.
// Honours CDB_BYPASS_EN the same way the design does (latency 1 instead of 2).

module tb_cdb_arbiter;

  localparam int BUF_DEPTH = 2;
  localparam int TAG_W     = 5;
  localparam int DATA_W    = 32;
  localparam int ROB_W     = 5;
  localparam int NFU       = 3;
  localparam int WAIT_MAX  = 3 * BUF_DEPTH;
`ifdef CDB_BYPASS_EN
  localparam int LAT    = 1;
  localparam bit BYPASS = 1'b1;
`else
  localparam int LAT    = 2;
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              flush_i;
  logic              in_v    [NFU];
  logic [TAG_W-1:0]  in_tag  [NFU];
  logic [DATA_W-1:0] in_data [NFU];
  logic [ROB_W-1:0]  in_rob  [NFU];
  logic              alu_ready_o, mul_ready_o, lsu_ready_o;
  logic              cdb_en_o;
  logic [TAG_W-1:0]  cdb_tag_o;
  logic [DATA_W-1:0] cdb_data_o;
  logic [ROB_W-1:0]  cdb_rob_idx_o;
  logic [2:0]        dut_rdy;

  assign dut_rdy = {lsu_ready_o, mul_ready_o, alu_ready_o};

  cdb_arbiter #(.BUF_DEPTH(BUF_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .alu_valid_i(in_v[0]), .alu_ready_o(alu_ready_o), .alu_tag_i(in_tag[0]),
    .alu_data_i(in_data[0]), .alu_rob_idx_i(in_rob[0]),
    .mul_valid_i(in_v[1]), .mul_ready_o(mul_ready_o), .mul_tag_i(in_tag[1]),
    .mul_data_i(in_data[1]), .mul_rob_idx_i(in_rob[1]),
    .lsu_valid_i(in_v[2]), .lsu_ready_o(lsu_ready_o), .lsu_tag_i(in_tag[2]),
    .lsu_data_i(in_data[2]), .lsu_rob_idx_i(in_rob[2]),
    .cdb_en_o(cdb_en_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o),
    .cdb_rob_idx_o(cdb_rob_idx_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: one queue per FU, a round-robin start index, and the expected CDB register.
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob;
  } ent_t;

  ent_t              mq [NFU][$];
  int                m_rr;
  logic              m_en;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_data;
  logic [ROB_W-1:0]  m_rob;
  int                m_grants;

  int checks = 0;
  int passed = 0;
  int dut_bcasts = 0;

  function automatic bit m_ready(int f);
    return mq[f].size() < BUF_DEPTH;
  endfunction

  function automatic logic [2:0] m_ready_vec();
    return {m_ready(2), m_ready(1), m_ready(0)};
  endfunction

  function automatic void model_step();
    bit rdy [NFU];
    int win;
    bit byp;
    for (int f = 0; f < NFU; f++) rdy[f] = m_ready(f);
    win = -1;
    byp = 1'b0;
    m_en = 1'b0; m_tag = '0; m_data = '0; m_rob = '0;
    if (reset_i || flush_i) begin
      for (int f = 0; f < NFU; f++) mq[f].delete();
      if (reset_i) m_rr = 0;
      return;
    end
    for (int k = 0; k < NFU; k++) begin
      int f;
      f = (m_rr + k) % NFU;
      if (win < 0) begin
        if (mq[f].size() > 0) win = f;
        else if (BYPASS && in_v[f] && rdy[f] && in_tag[f] != 0) begin
          win = f;
          byp = 1'b1;
        end
      end
    end
    if (win >= 0) begin
      ent_t e;
      if (byp) begin
        e.tag = in_tag[win]; e.data = in_data[win]; e.rob = in_rob[win];
      end else begin
        e = mq[win].pop_front();
      end
      m_en = 1'b1; m_tag = e.tag; m_data = e.data; m_rob = e.rob;
      m_grants++;
      m_rr = (win == 2) ? 0 : win + 1;
    end
    for (int f = 0; f < NFU; f++) begin
      if (in_v[f] && rdy[f] && in_tag[f] != 0 && !(byp && win == f)) begin
        ent_t e;
        e.tag = in_tag[f]; e.data = in_data[f]; e.rob = in_rob[f];
        mq[f].push_back(e);
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    if (cdb_en_o === 1'b1) dut_bcasts++;
  endtask

  task automatic clear_inputs();
    for (int f = 0; f < NFU; f++) begin
      in_v[f] = 1'b0; in_tag[f] = '0; in_data[f] = '0; in_rob[f] = '0;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    flush_i = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset_i = 1'b1;
    flush_i = 1'b0;
    for (int f = 0; f < NFU; f++) begin
      in_v[f] = 1'b1; in_tag[f] = TAG_W'(f + 1); in_data[f] = 32'hdead0000 + f; in_rob[f] = ROB_W'(f);
    end
    tick();
    tick();
    checks++;
    if (cdb_en_o !== 1'b0) $display("[TB] FAIL reset_en got=%b exp=0", cdb_en_o);
    else passed++;
    checks++;
    if ({cdb_tag_o, cdb_data_o, cdb_rob_idx_o} !== '0)
      $display("[TB] FAIL reset_payload got tag=%0d data=%h rob=%0d exp=0", cdb_tag_o, cdb_data_o, cdb_rob_idx_o);
    else passed++;
    reset_i = 1'b0;
    clear_inputs();
    checks++;
    if (dut_rdy !== 3'b111) $display("[TB] FAIL reset_ready got=%b exp=111", dut_rdy);
    else passed++;
  endtask

  task automatic test_single();
    $display("[TB] test_single");
    do_reset();
    in_v[0] = 1'b1; in_tag[0] = 5'd7; in_data[0] = 32'h11; in_rob[0] = 5'd3;
    tick();
    clear_inputs();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (cdb_en_o !== (c == LAT)) $display("[TB] FAIL single_en cyc=%0d got=%b exp=%b", c, cdb_en_o, (c == LAT));
      else passed++;
      if (c == LAT) begin
        checks++;
        if (cdb_tag_o !== 5'd7 || cdb_data_o !== 32'h11 || cdb_rob_idx_o !== 5'd3)
          $display("[TB] FAIL single_payload got tag=%0d data=%h rob=%0d exp tag=7 data=11 rob=3",
                   cdb_tag_o, cdb_data_o, cdb_rob_idx_o);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    $display("[TB] test_round_robin");
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int f = 0; f < NFU; f++) begin
        in_v[f] = 1'b1; in_tag[f] = TAG_W'(f + 1); in_data[f] = 32'ha0 + 16 * r + f; in_rob[f] = ROB_W'(f + 4);
      end
      tick();
      clear_inputs();
      for (int c = 1; c <= LAT + 3; c++) begin
        logic             exp_en;
        logic [TAG_W-1:0] exp_tag;
        exp_en  = (c >= LAT && c <= LAT + 2);
        exp_tag = exp_en ? TAG_W'(c - LAT + 1) : '0;
        checks++;
        if (cdb_en_o !== exp_en || cdb_tag_o !== exp_tag)
          $display("[TB] FAIL rr_order round=%0d cyc=%0d got en=%b tag=%0d exp en=%b tag=%0d",
                   r, c, cdb_en_o, cdb_tag_o, exp_en, exp_tag);
        else passed++;
        tick();
      end
    end
  endtask

  task automatic test_mul_burst();
    logic [TAG_W-1:0] got [$];
    int sent;
    int guard;
    bit acc;
    $display("[TB] test_mul_burst");
    do_reset();
    sent = 0;
    guard = 0;
    while (sent < 3 && guard < 20) begin
      in_v[1] = 1'b1; in_tag[1] = TAG_W'(4 + sent); in_data[1] = 32'h100 + sent; in_rob[1] = ROB_W'(sent);
      checks++;
      if (mul_ready_o !== m_ready(1)) $display("[TB] FAIL mul_ready got=%b exp=%b", mul_ready_o, m_ready(1));
      else passed++;
      acc = m_ready(1);
      tick();
      if (acc) sent++;
      if (cdb_en_o === 1'b1) got.push_back(cdb_tag_o);
      guard++;
    end
    checks++;
    if (sent != 3) $display("[TB] FAIL mul_push_timeout got=%0d exp=3", sent);
    else passed++;
    clear_inputs();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (cdb_en_o === 1'b1) got.push_back(cdb_tag_o);
    end
    checks++;
    if (got.size() != 3) $display("[TB] FAIL mul_count got=%0d exp=3", got.size());
    else passed++;
    for (int i = 0; i < 3; i++) begin
      if (got.size() > i) begin
        checks++;
        if (got[i] !== TAG_W'(4 + i)) $display("[TB] FAIL mul_order idx=%0d got=%0d exp=%0d", i, got[i], 4 + i);
        else passed++;
      end
    end
  endtask

  task automatic test_tag_zero();
    $display("[TB] test_tag_zero");
    do_reset();
    in_v[0] = 1'b1; in_tag[0] = '0; in_data[0] = 32'h55; in_rob[0] = 5'd1;
    checks++;
    if (alu_ready_o !== 1'b1) $display("[TB] FAIL tag0_ready got=%b exp=1", alu_ready_o);
    else passed++;
    tick();
    clear_inputs();
    checks++;
    if (alu_ready_o !== 1'b1) $display("[TB] FAIL tag0_not_queued got=%b exp=1", alu_ready_o);
    else passed++;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (cdb_en_o !== 1'b0) $display("[TB] FAIL tag0_en cyc=%0d got=%b exp=0", c, cdb_en_o);
      else passed++;
      tick();
    end
  endtask

  task automatic test_flush();
    int seq;
    $display("[TB] test_flush");
    do_reset();
    seq = 0;
    for (int i = 0; i < 8; i++) begin
      for (int f = 0; f < NFU; f++) begin
        in_v[f] = 1'b1; in_tag[f] = TAG_W'((seq % 31) + 1); in_data[f] = $urandom; in_rob[f] = ROB_W'(seq);
        seq++;
      end
      checks++;
      if (dut_rdy !== m_ready_vec()) $display("[TB] FAIL fill_ready got=%b exp=%b", dut_rdy, m_ready_vec());
      else passed++;
      tick();
    end
    flush_i = 1'b1;
    clear_inputs();
    in_v[2] = 1'b1; in_tag[2] = 5'd9; in_data[2] = 32'h99; in_rob[2] = 5'd9;
    tick();
    flush_i = 1'b0;
    clear_inputs();
    checks++;
    if (cdb_en_o !== 1'b0) $display("[TB] FAIL flush_en got=%b exp=0", cdb_en_o);
    else passed++;
    checks++;
    if (dut_rdy !== 3'b111) $display("[TB] FAIL flush_ready got=%b exp=111", dut_rdy);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (cdb_en_o !== 1'b0) $display("[TB] FAIL flush_after cyc=%0d got=%b exp=0", c, cdb_en_o);
      else passed++;
    end
  endtask

  task automatic test_random();
    int sb_seq   [NFU][$];
    int sb_stamp [NFU][$];
    int seqn     [NFU];
    bit acc      [NFU];
    bit flush_now;
    int waitmax;
    $display("[TB] test_random");
    do_reset();
    for (int f = 0; f < NFU; f++) seqn[f] = 0;
    waitmax = 0;
    for (int cyc = 0; cyc < 10000 + 20; cyc++) begin
      if (cyc < 10000) begin
        flush_i = ($urandom_range(0, 499) == 0);
        for (int f = 0; f < NFU; f++) begin
          in_v[f]    = ($urandom_range(0, 2) != 0);
          in_tag[f]  = ($urandom_range(0, 15) == 0) ? '0 : TAG_W'($urandom_range(1, 31));
          in_rob[f]  = ROB_W'($urandom);
          in_data[f] = {2'(f), 30'(seqn[f])};
        end
      end else begin
        flush_i = 1'b0;
        clear_inputs();
      end
      checks++;
      if (dut_rdy !== m_ready_vec()) $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, dut_rdy, m_ready_vec());
      else passed++;
      for (int f = 0; f < NFU; f++) acc[f] = in_v[f] && m_ready(f) && in_tag[f] != 0 && !flush_i;
      flush_now = flush_i;
      tick();
      checks++;
      if ({cdb_en_o, cdb_tag_o, cdb_data_o, cdb_rob_idx_o} !== {m_en, m_tag, m_data, m_rob})
        $display("[TB] FAIL rnd_cdb cyc=%0d got en=%b tag=%0d data=%h rob=%0d exp en=%b tag=%0d data=%h rob=%0d",
                 cyc, cdb_en_o, cdb_tag_o, cdb_data_o, cdb_rob_idx_o, m_en, m_tag, m_data, m_rob);
      else passed++;
      if (flush_now) begin
        for (int f = 0; f < NFU; f++) begin
          sb_seq[f].delete();
          sb_stamp[f].delete();
        end
      end else begin
        for (int f = 0; f < NFU; f++) begin
          if (acc[f]) begin
            sb_seq[f].push_back(seqn[f]);
            sb_stamp[f].push_back(dut_bcasts);
            seqn[f]++;
          end
        end
      end
      if (cdb_en_o === 1'b1) begin
        int fu;
        int sq;
        fu = int'(cdb_data_o[31:30]);
        sq = int'(cdb_data_o[29:0]);
        checks++;
        if (fu >= NFU || sb_seq[fu].size() == 0) begin
          $display("[TB] FAIL rnd_unexpected cyc=%0d got fu=%0d seq=%0d exp no broadcast", cyc, fu, sq);
        end else begin
          int exp_sq;
          int w;
          exp_sq = sb_seq[fu].pop_front();
          w = dut_bcasts - sb_stamp[fu].pop_front();
          if (w > waitmax) waitmax = w;
          if (sq != exp_sq) $display("[TB] FAIL rnd_order cyc=%0d fu=%0d got seq=%0d exp=%0d", cyc, fu, sq, exp_sq);
          else passed++;
        end
      end
    end
    checks++;
    if (sb_seq[0].size() + sb_seq[1].size() + sb_seq[2].size() != 0)
      $display("[TB] FAIL rnd_lost got pending=%0d exp=0", sb_seq[0].size() + sb_seq[1].size() + sb_seq[2].size());
    else passed++;
    checks++;
    if (waitmax > WAIT_MAX) $display("[TB] FAIL rnd_fairness got wait=%0d exp<=%0d", waitmax, WAIT_MAX);
    else passed++;
    checks++;
    if (dut_bcasts != m_grants) $display("[TB] FAIL rnd_bcast_count got=%0d exp=%0d", dut_bcasts, m_grants);
    else passed++;
  endtask

  initial begin
    m_rr = 0;
    m_grants = 0;
    m_en = 1'b0; m_tag = '0; m_data = '0; m_rob = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_mul_burst();
    test_tag_zero();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
